// File: rtl/fallthrough_small_fifo_core.sv
// First-word-fall-through FIFO on a register array: the head word is always on
// dout while non-empty, and rd_en pops it with no read latency.
module fallthrough_small_fifo_core #(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 2**MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] DEPTH_C  = (MAX_DEPTH_BITS+1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] THRESH_C = (MAX_DEPTH_BITS+1)'(PROG_FULL_THRESHOLD);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   count_q, count_d;
  logic                      rd_ok, wr_ok;

  // A full FIFO still accepts a write when the same edge pops the head.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; the decoded flags make stale contents invisible.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= din;
  end

  assign dout        = mem[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign nearly_full = (count_q >= THRESH_C);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && wr_en && full && !rd_ok)
      $display("%m warning: write while full, word dropped at %0t", $time);
    if (!reset && rd_en && empty)
      $display("%m warning: read while empty, ignored at %0t", $time);
  end
`endif

endmodule

// File: tb/tb_fallthrough_small_fifo_core.sv
// Scoreboard bench for fallthrough_small_fifo_core: a reference queue tracks
// accepted words and flags are checked against its occupancy every cycle.
module tb_fallthrough_small_fifo_core;

  localparam int WIDTH = 72;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] dout;
  logic             full, nearly_full, empty;

  logic [WIDTH-1:0] sb [$];
  int n_checks = 0;
  int n_errors = 0;

  fallthrough_small_fifo_core #(.WIDTH(WIDTH), .MAX_DEPTH_BITS(3)) dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .nearly_full(nearly_full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = sb.size();
    check({tag, ".empty"}, WIDTH'(empty), WIDTH'(n == 0));
    check({tag, ".full"}, WIDTH'(full), WIDTH'(n == DEPTH));
    check({tag, ".nearly_full"}, WIDTH'(nearly_full), WIDTH'(n >= DEPTH - 1));
    if (n > 0) check({tag, ".dout"}, dout, sb[0]);
  endtask

  // One clock: drive, update the reference at the edge, then check 1 time unit later.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [WIDTH-1:0] d);
    logic rd_acc, wr_acc;
    wr_en = w; rd_en = r; din = d;
    @(posedge clk);
    rd_acc = r && (sb.size() > 0);
    wr_acc = w && ((sb.size() < DEPTH) || rd_acc);
    if (rd_acc) void'(sb.pop_front());
    if (wr_acc) sb.push_back(d);
    #1;
    $display("txn %-8s wr=%0b rd=%0b din=%0h -> occ=%0d empty=%0b full=%0b nf=%0b dout=%0h",
             tag, w, r, d, sb.size(), empty, full, nearly_full, dout);
    check_state(tag);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    #1;
    check_state("por");
    @(posedge clk); #1;
    reset = 1'b0;

    // Asynchronous reset while holding three words, checked before any edge.
    for (int i = 0; i < 3; i++) cycle("fill3", 1'b1, 1'b0, WIDTH'(32'h30 + i));
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check_state("areset");
    @(posedge clk); #1;
    check_state("areset_hold");
    reset = 1'b0;

    // Single-word fall-through and pop.
    cycle("wr11", 1'b1, 1'b0, WIDTH'(8'h11));
    check("wr11.dout_lit", dout, WIDTH'(8'h11));
    cycle("rd11", 1'b0, 1'b1, '0);

    // Fill to full, drop an overflow write, drain in order.
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 1'b0, WIDTH'(i));
    cycle("ovf99", 1'b1, 1'b0, WIDTH'(8'h99));
    for (int i = 1; i <= 8; i++) begin
      check("drain.order", dout, WIDTH'(i));
      cycle("drain", 1'b0, 1'b1, '0);
    end

    // Simultaneous read and write while full.
    for (int i = 1; i <= 8; i++) cycle("refill", 1'b1, 1'b0, WIDTH'(i));
    cycle("fullrw", 1'b1, 1'b1, WIDTH'(8'hAA));
    check("fullrw.dout2", dout, WIDTH'(2));
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("fullrw.lastAA", dout, WIDTH'(8'hAA));
      cycle("drainAA", 1'b0, 1'b1, '0);
    end

    // Streaming with occupancy held at one across pointer wrap-around.
    cycle("str0", 1'b1, 1'b0, {8'hC0, 64'h0123_4567_89AB_CDEF});
    for (int i = 1; i < 20; i++) cycle("stream", 1'b1, 1'b1, {8'hC0 + 8'(i), 64'($urandom)});
    cycle("strend", 1'b0, 1'b1, '0);

    // Read on empty is ignored; a write with read on empty is accepted.
    cycle("rdempty", 1'b0, 1'b1, '0);
    cycle("rwempty", 1'b1, 1'b1, WIDTH'(8'h5A));
    check("rwempty.dout", dout, WIDTH'(8'h5A));
    cycle("rwdrain", 1'b0, 1'b1, '0);

    wr_en = 1'b0; rd_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
